// File: rtl/demux1to2_stream.sv
// demux1to2_stream: routes one input word stream to one of two buffered,
// independently back-pressured output streams, chosen per word by i_sel.
module demux1to2_stream #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNTW  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_sel,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data0,
   output logic             o_valid0,
   input  logic             i_ready0,
   output logic [WIDTH-1:0] o_data1,
   output logic             o_valid1,
   input  logic             i_ready1,
   output logic [CNTW-1:0]  o_count0,
   output logic [CNTW-1:0]  o_count1
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned OCW = AW + 1;

   logic [1:0]       valid_w;
   logic [1:0]       full_w;
   logic [WIDTH-1:0] data_w [2];
   logic [CNTW-1:0]  cnt_w  [2];

   // Accept depends only on the selected lane's registered full flag.
   assign o_ready = i_sel ? ~full_w[1] : ~full_w[0];

   for (genvar g = 0; g < 2; g++) begin : gen_lane
      logic             push;
      logic             pop;
      logic             lane_sel;
      logic             lane_rdy;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [AW-1:0]    wr_q, wr_d;
      logic [AW-1:0]    rd_q, rd_d;
      logic [OCW-1:0]   occ_q, occ_d;
      logic [CNTW-1:0]  cnt_q, cnt_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             valid_q, valid_d;
      logic             full_q, full_d;

      assign lane_sel = (g == 1) ? i_sel : ~i_sel;
      assign lane_rdy = (g == 1) ? i_ready1 : i_ready0;
      assign push     = i_valid & o_ready & lane_sel;
      assign pop      = valid_q & lane_rdy;

      // Next FIFO state; the output head register is loaded with the word
      // that will sit at the read pointer after this edge.
      always_comb begin
         mem_d   = mem_q;
         wr_d    = wr_q;
         rd_d    = rd_q;
         occ_d   = occ_q;
         cnt_d   = cnt_q;
         data_d  = data_q;
         if (push) begin
            mem_d[wr_q] = i_data;
            wr_d        = AW'(wr_q + 1'b1);
         end
         if (pop) begin
            rd_d  = AW'(rd_q + 1'b1);
            cnt_d = CNTW'(cnt_q + 1'b1);
         end
         if (push && !pop) begin
            occ_d = OCW'(occ_q + 1'b1);
         end else if (!push && pop) begin
            occ_d = OCW'(occ_q - 1'b1);
         end
         if (push && (occ_q == (pop ? OCW'(1) : OCW'(0)))) begin
            data_d = i_data;
         end else if (occ_d != '0) begin
            data_d = mem_q[rd_d];
         end
         valid_d = (occ_d != '0);
         full_d  = (occ_d == OCW'(DEPTH));
      end

      // Lane state registers, cleared asynchronously.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
         end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            full_q  <= full_d;
         end
      end

      assign valid_w[g] = valid_q;
      assign full_w[g]  = full_q;
      assign data_w[g]  = data_q;
      assign cnt_w[g]   = cnt_q;
   end

   assign o_data0  = data_w[0];
   assign o_data1  = data_w[1];
   assign o_valid0 = valid_w[0];
   assign o_valid1 = valid_w[1];
   assign o_count0 = cnt_w[0];
   assign o_count1 = cnt_w[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: directed scenarios followed by
// random traffic, all checked against queue-based per-output models.
`timescale 1ns/1ps
module tb_demux1to2_stream;

   localparam int unsigned WIDTH = 6;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNTW  = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] i_data = '0;
   logic             i_sel = 1'b0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [WIDTH-1:0] o_data0, o_data1;
   logic             o_valid0, o_valid1;
   logic             i_ready0 = 1'b0;
   logic             i_ready1 = 1'b0;
   logic [CNTW-1:0]  o_count0, o_count1;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   // Model: words accepted and not yet delivered, per output, plus counts.
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   int               cnt0 = 0;
   int               cnt1 = 0;

   demux1to2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (i_data),
      .i_sel   (i_sel),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data0 (o_data0),
      .o_valid0(o_valid0),
      .i_ready0(i_ready0),
      .o_data1 (o_data1),
      .o_valid1(o_valid1),
      .i_ready1(i_ready1),
      .o_count0(o_count0),
      .o_count1(o_count1)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Mid-cycle monitor: compare DUT against the model, then apply the
   // handshakes that the coming rising edge will perform.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         bit exp_rdy;
         bit pop0, pop1;
         exp_rdy = i_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
         check("o_ready", 32'(o_ready), 32'(exp_rdy));
         check("o_valid0", 32'(o_valid0), 32'(q0.size() != 0));
         check("o_valid1", 32'(o_valid1), 32'(q1.size() != 0));
         if (q0.size() != 0) check("o_data0", 32'(o_data0), 32'(q0[0]));
         if (q1.size() != 0) check("o_data1", 32'(o_data1), 32'(q1[0]));
         check("o_count0", 32'(o_count0), 32'(cnt0));
         check("o_count1", 32'(o_count1), 32'(cnt1));
         pop0 = (q0.size() != 0) && i_ready0;
         pop1 = (q1.size() != 0) && i_ready1;
         if (pop0) begin
            void'(q0.pop_front());
            cnt0 = (cnt0 + 1) % (1 << CNTW);
         end
         if (pop1) begin
            void'(q1.pop_front());
            cnt1 = (cnt1 + 1) % (1 << CNTW);
         end
         if (i_valid && exp_rdy) begin
            if (i_sel) q1.push_back(i_data);
            else       q0.push_back(i_data);
         end
      end
   end

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one word and hold it until the DUT accepts it.
   task automatic send(input logic sel, input logic [WIDTH-1:0] d);
      int budget = 50;
      i_valid = 1'b1;
      i_sel   = sel;
      i_data  = d;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         budget--;
         if (budget == 0) begin
            check("send_timeout", 32'(0), 32'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Assert reset between edges and check that state clears at once.
   task automatic async_reset();
      i_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid0", 32'(o_valid0), 32'(0));
      check("rst_valid1", 32'(o_valid1), 32'(0));
      check("rst_count0", 32'(o_count0), 32'(0));
      check("rst_count1", 32'(o_count1), 32'(0));
      check("rst_data0", 32'(o_data0), 32'(0));
      check("rst_data1", 32'(o_data1), 32'(0));
      q0.delete();
      q1.delete();
      cnt0 = 0;
      cnt1 = 0;
      #2;
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(o_ready), 32'(1));
      idle(1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #13;
      check("por_valid0", 32'(o_valid0), 32'(0));
      check("por_count0", 32'(o_count0), 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Single word to output 0, latency and delivery.
      i_ready0 = 1'b0;
      send(1'b0, 6'h15);
      @(negedge clk);
      check("first_data0", 32'(o_data0), 32'h15);
      check("first_valid1", 32'(o_valid1), 32'(0));
      @(posedge clk); #1;
      i_ready0 = 1'b1;
      idle(1);
      i_ready0 = 1'b0;
      @(negedge clk);
      check("first_popped", 32'(o_valid0), 32'(0));
      check("first_count0", 32'(o_count0), 32'(1));
      @(posedge clk); #1;

      // Stall output 1 until full; output 0 keeps flowing.
      i_ready1 = 1'b0;
      send(1'b1, 6'h01);
      send(1'b1, 6'h02);
      i_sel = 1'b1;
      @(negedge clk);
      check("full1_ready", 32'(o_ready), 32'(0));
      @(posedge clk); #1;
      i_ready0 = 1'b1;
      send(1'b0, 6'h2A);
      idle(2);
      i_ready0 = 1'b0;

      // Release output 1 in the same cycle 0x03 is offered.
      i_ready1 = 1'b1;
      send(1'b1, 6'h03);
      idle(4);
      i_ready1 = 1'b0;

      // Push and pop together on a one-entry FIFO.
      send(1'b0, 6'h10);
      i_ready0 = 1'b1;
      send(1'b0, 6'h07);
      i_ready0 = 1'b0;
      @(negedge clk);
      check("pushpop_head", 32'(o_data0), 32'h07);
      @(posedge clk); #1;
      i_ready0 = 1'b1;
      idle(2);

      // Counter wrap over 260 deliveries from a clean start.
      async_reset();
      i_ready0 = 1'b1;
      for (int i = 0; i < 260; i++) send(1'b0, WIDTH'($urandom));
      idle(3);
      @(negedge clk);
      check("wrap_count0", 32'(o_count0), 32'(4));
      @(posedge clk); #1;

      // Reset with both FIFOs holding data, then first word after reset.
      i_ready0 = 1'b0;
      i_ready1 = 1'b0;
      send(1'b0, 6'h11);
      send(1'b1, 6'h22);
      send(1'b0, 6'h33);
      async_reset();
      send(1'b1, 6'h3C);
      @(negedge clk);
      check("post_rst_head1", 32'(o_data1), 32'h3C);
      @(posedge clk); #1;

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         i_valid  = ($urandom_range(0, 3) != 0);
         i_sel    = 1'($urandom);
         i_data   = WIDTH'($urandom);
         i_ready0 = ($urandom_range(0, 2) != 0);
         i_ready1 = ($urandom_range(0, 3) == 0);
         idle(1);
      end
      i_valid  = 1'b0;
      i_ready0 = 1'b1;
      i_ready1 = 1'b1;
      idle(6);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
